// File: rtl/request_capture_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : request_capture_arbiter
// Description : Feeder stage for the priority encoder path. Single-cycle
//               request pulses are captured into a sticky pending vector.
//               A per-source mask decides which pending sources may be
//               granted. The highest-index eligible source is presented on a
//               registered valid/ready output. A request is retired only
//               when the consumer accepts its grant.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1            rising-edge clock
//   rst_n        in   1            synchronous reset, active-low
//   req_in       in   NUM_INPUTS   request pulses, bit i marks source i
//   mask_in      in   NUM_INPUTS   1 = source eligible for grant
//   clear_all    in   1            synchronous flush of pending/overflow/grant
//   grant_idx    out  IDX_W        granted source index (qualified by valid)
//   grant_valid  out  1            grant_idx holds a live grant
//   grant_ready  in   1            consumer accepts the current grant
//   pending_out  out  NUM_INPUTS   registered pending vector
//   overflow     out  NUM_INPUTS   sticky: request hit an already-pending source
// ============================================================================
module request_capture_arbiter #(
  parameter int NUM_INPUTS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_INPUTS-1:0]         req_in,
  input  logic [NUM_INPUTS-1:0]         mask_in,
  input  logic                          clear_all,
  output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
  output logic                          grant_valid,
  input  logic                          grant_ready,
  output logic [NUM_INPUTS-1:0]         pending_out,
  output logic [NUM_INPUTS-1:0]         overflow
);

  localparam int IDX_W = $clog2(NUM_INPUTS);

  // State registers
  logic [NUM_INPUTS-1:0] pending_q,     pending_d;
  logic [NUM_INPUTS-1:0] overflow_q,    overflow_d;
  logic [IDX_W-1:0]      grant_idx_q,   grant_idx_d;
  logic                  grant_valid_q, grant_valid_d;

  // Combinational helpers
  logic                  w_accept;
  logic                  w_load;
  logic [NUM_INPUTS-1:0] w_acc_oh;
  logic [NUM_INPUTS-1:0] w_hold_oh;
  logic [NUM_INPUTS-1:0] w_cand;
  logic [IDX_W-1:0]      w_sel;

  assign w_accept = grant_valid_q & grant_ready;
  // The output register may only change when it is empty or being drained.
  assign w_load   = ~grant_valid_q | w_accept;

  // One-hot views of the current grant: acc_oh retires the accepted source,
  // hold_oh keeps the in-flight source out of the next selection.
  always_comb begin
    w_acc_oh  = '0;
    w_hold_oh = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        w_acc_oh[i]  = w_accept;
        w_hold_oh[i] = grant_valid_q;
      end
    end
  end

  assign w_cand = pending_q & mask_in & ~w_acc_oh & ~w_hold_oh;

  // Ascending scan: the last hit wins, so the highest index has priority.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (w_cand[i]) begin
        w_sel = IDX_W'(i);
      end
    end
  end

  // Next-state logic
  always_comb begin
    pending_d     = pending_q;
    overflow_d    = overflow_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;

    if (clear_all) begin
      // Flush wins over any same-cycle request or acceptance.
      pending_d     = '0;
      overflow_d    = '0;
      grant_idx_d   = '0;
      grant_valid_d = 1'b0;
    end else begin
      // A request coinciding with acceptance of the same source re-pends
      // it without flagging overflow.
      pending_d  = (pending_q & ~w_acc_oh) | req_in;
      overflow_d = overflow_q | (req_in & pending_q & ~w_acc_oh);
      if (w_load) begin
        grant_valid_d = |w_cand;
        if (|w_cand) begin
          grant_idx_d = w_sel;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q     <= '0;
      overflow_q    <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign pending_out = pending_q;
  assign overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_request_capture_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_request_capture_arbiter
// Description : Directed self-checking bench for request_capture_arbiter.
//               Inputs change 1 time unit after a rising edge; outputs are
//               checked at the same point, before new inputs are applied.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_request_capture_arbiter;

  localparam int NUM_INPUTS = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic [3:0] mask_in;
  logic       clear_all;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       grant_ready;
  logic [3:0] pending_out;
  logic [3:0] overflow;

  int n_tests;
  int n_fail;

  request_capture_arbiter #(.NUM_INPUTS(NUM_INPUTS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_in      (req_in),
    .mask_in     (mask_in),
    .clear_all   (clear_all),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .pending_out (pending_out),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    req_in      = 4'hF;
    mask_in     = 4'hF;
    clear_all   = 1'b0;
    grant_ready = 1'b0;

    // 1 Reset with all requests asserted
    cycle();
    cycle();
    check("rst_pending", pending_out, 4'h0);
    check("rst_overflow", overflow, 4'h0);
    check("rst_valid", grant_valid, 1'b0);
    rst_n  = 1'b1;
    req_in = 4'h0;
    cycle();
    check("idle_pending", pending_out, 4'h0);
    check("idle_valid", grant_valid, 1'b0);

    // 2 Latency and priority
    grant_ready = 1'b1;
    req_in      = 4'b0101;
    cycle();
    req_in = 4'h0;
    check("lat_pending", pending_out, 4'b0101);
    check("lat_valid_early", grant_valid, 1'b0);
    cycle();
    check("lat_valid1", grant_valid, 1'b1);
    check("lat_idx1", grant_idx, 2'd2);
    check("lat_pending1", pending_out, 4'b0101);
    cycle();
    check("lat_valid2", grant_valid, 1'b1);
    check("lat_idx2", grant_idx, 2'd0);
    check("lat_pending2", pending_out, 4'b0001);
    cycle();
    check("lat_valid3", grant_valid, 1'b0);
    check("lat_pending3", pending_out, 4'b0000);

    // 3 Backpressure
    grant_ready = 1'b0;
    req_in      = 4'b1000;
    cycle();
    req_in = 4'h0;
    cycle();
    check("bp_valid", grant_valid, 1'b1);
    check("bp_idx", grant_idx, 2'd3);
    req_in = 4'b0010;
    cycle();
    req_in = 4'h0;
    check("bp_pending", pending_out, 4'b1010);
    check("bp_idx_hold1", grant_idx, 2'd3);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("bp_idx_hold", grant_idx, 2'd3);
      check("bp_valid_hold", grant_valid, 1'b1);
    end
    grant_ready = 1'b1;
    cycle();
    check("bp_next_valid", grant_valid, 1'b1);
    check("bp_next_idx", grant_idx, 2'd1);
    check("bp_next_pending", pending_out, 4'b0010);
    cycle();
    check("bp_drain_valid", grant_valid, 1'b0);
    check("bp_drain_pending", pending_out, 4'b0000);

    // 4 Overflow and re-pend on accept
    grant_ready = 1'b0;
    req_in      = 4'b0010;
    cycle();
    check("ov_none_yet", overflow, 4'b0000);
    cycle();
    check("ov_set", overflow, 4'b0010);
    check("ov_grant_idx", grant_idx, 2'd1);
    check("ov_grant_valid", grant_valid, 1'b1);
    grant_ready = 1'b1;
    cycle();
    req_in = 4'h0;
    check("ov_repend_pending", pending_out, 4'b0010);
    check("ov_repend_overflow", overflow, 4'b0010);
    check("ov_repend_valid", grant_valid, 1'b0);
    cycle();
    check("ov_regrant_valid", grant_valid, 1'b1);
    check("ov_regrant_idx", grant_idx, 2'd1);
    cycle();
    check("ov_done_valid", grant_valid, 1'b0);
    check("ov_done_pending", pending_out, 4'b0000);

    // 5 Mask gating
    mask_in = 4'b0011;
    req_in  = 4'b1100;
    cycle();
    req_in = 4'h0;
    cycle();
    check("mask_no_grant", grant_valid, 1'b0);
    check("mask_pending", pending_out, 4'b1100);
    mask_in = 4'hF;
    cycle();
    check("mask_g3_valid", grant_valid, 1'b1);
    check("mask_g3_idx", grant_idx, 2'd3);
    cycle();
    check("mask_g2_valid", grant_valid, 1'b1);
    check("mask_g2_idx", grant_idx, 2'd2);
    check("mask_g2_pending", pending_out, 4'b0100);
    cycle();
    check("mask_done_valid", grant_valid, 1'b0);

    // 6 clear_all against a live accept and full request vector
    grant_ready = 1'b0;
    req_in      = 4'b0001;
    cycle();
    req_in = 4'h0;
    cycle();
    check("clr_pre_valid", grant_valid, 1'b1);
    check("clr_pre_idx", grant_idx, 2'd0);
    clear_all   = 1'b1;
    grant_ready = 1'b1;
    req_in      = 4'hF;
    cycle();
    clear_all = 1'b0;
    req_in    = 4'h0;
    check("clr_pending", pending_out, 4'h0);
    check("clr_overflow", overflow, 4'h0);
    check("clr_valid", grant_valid, 1'b0);
    cycle();
    check("clr_after_valid", grant_valid, 1'b0);
    check("clr_after_pending", pending_out, 4'h0);

    // Reset in the middle of a stalled grant drops it
    grant_ready = 1'b0;
    req_in      = 4'b0100;
    cycle();
    req_in = 4'h0;
    cycle();
    check("mrst_pre_valid", grant_valid, 1'b1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("mrst_valid", grant_valid, 1'b0);
    check("mrst_pending", pending_out, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
